// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler: round-robin arbiter handing a shared convolution core to two requesters, with run timeout.
module conv_job_scheduler #(
   parameter int SIZE_WIDTH     = 5,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            req_valid,
   input  logic [SIZE_WIDTH-1:0] req_size0,
   input  logic [SIZE_WIDTH-1:0] req_size1,
   output logic [1:0]            req_ready,
   output logic [1:0]            done_pulse,
   output logic [1:0]            err_timeout,
   output logic                  core_start,
   output logic [SIZE_WIDTH-1:0] core_size,
   input  logic                  core_done,
   output logic                  sel,
   output logic                  sched_busy
);
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] GRANT  = 3'd1;
   localparam logic [2:0] LAUNCH = 3'd2;
   localparam logic [2:0] RUN    = 3'd3;
   localparam logic [2:0] FINISH = 3'd4;
   localparam logic [2:0] ABORT  = 3'd5;
   logic [2:0]    state;
   logic          last_grant;
   logic [CW-1:0] cnt;
   logic          w;
   logic [1:0]    owner;
   assign w     = &req_valid ? ~last_grant : req_valid[1];
   assign owner = sel ? 2'b10 : 2'b01;
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         sel        <= 1'b0;
         core_size  <= '0;
         cnt        <= '0;
      end else begin
         case (state)
            IDLE: if (|req_valid) begin
               sel       <= w;
               core_size <= w ? req_size1 : req_size0;
               state     <= GRANT;
            end
            GRANT: state <= (core_size == '0) ? FINISH : LAUNCH;
            LAUNCH: begin
               cnt   <= '0;
               state <= RUN;
            end
            // a done arriving on the threshold cycle takes priority over the abort
            RUN: begin
               cnt <= cnt + CW'(1);
               if (core_done) state <= FINISH;
               else if (cnt == CW'(TIMEOUT_CYCLES - 1)) state <= ABORT;
            end
            FINISH, ABORT: begin
               last_grant <= sel;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign req_ready   = (state == GRANT)  ? owner : 2'b00;
   assign done_pulse  = (state == FINISH) ? owner : 2'b00;
   assign err_timeout = (state == ABORT)  ? owner : 2'b00;
   assign core_start  = state == LAUNCH;
   assign sched_busy  = state != IDLE;
endmodule

// File: tb/tb_conv_job_scheduler.sv
// tb_conv_job_scheduler: directed checks of arbitration, latency, zero-size jobs, timeout and reset.
module tb_conv_job_scheduler;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [4:0] req_size0 = 5'd0;
   logic [4:0] req_size1 = 5'd0;
   logic       core_done = 1'b0;
   logic [1:0] ready_a, done_a, err_a, ready_b, done_b, err_b;
   logic       start_a, sel_a, busy_a, start_b, sel_b, busy_b;
   logic [4:0] size_a, size_b;
   int         n_tests = 0;
   int         n_fail = 0;
   always #5 clk = ~clk;
   conv_job_scheduler u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_size0(req_size0), .req_size1(req_size1),
      .req_ready(ready_a), .done_pulse(done_a), .err_timeout(err_a), .core_start(start_a),
      .core_size(size_a), .core_done(core_done), .sel(sel_a), .sched_busy(busy_a)
   );
   // short-timeout copy for the abort scenarios
   conv_job_scheduler #(.TIMEOUT_CYCLES(8)) u_dut_to (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_size0(req_size0), .req_size1(req_size1),
      .req_ready(ready_b), .done_pulse(done_b), .err_timeout(err_b), .core_start(start_b),
      .core_size(size_b), .core_done(core_done), .sel(sel_b), .sched_busy(busy_b)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic run_job(input logic s, input logic [4:0] sz, input int n, input logic drop);
      tick();
      check("grant_ready", 32'(ready_a), s ? 32'h2 : 32'h1);
      check("grant_sel", 32'(sel_a), 32'(s));
      if (drop) req_valid = 2'b00;
      tick();
      check("launch_start", 32'(start_a), 32'h1);
      check("launch_size", 32'(size_a), 32'(sz));
      tick();
      for (int i = 1; i < n; i++) begin
         if (done_a !== 2'b00 || start_a !== 1'b0) check("run_quiet", {done_a, start_a}, 32'h0);
         tick();
      end
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check("finish_done", 32'(done_a), s ? 32'h2 : 32'h1);
      check("finish_sel", 32'(sel_a), 32'(s));
      check("finish_size", 32'(size_a), 32'(sz));
      tick();
      check("idle_busy", 32'(busy_a), 32'h0);
   endtask
   initial begin
      tick();
      tick();
      check("rst_outputs", {ready_a, done_a, err_a, start_a, busy_a, sel_a, size_a}, 32'h0);
      rst = 1'b0;
      tick();
      check("rst_idle", {ready_a, done_a, err_a, start_a, busy_a}, 32'h0);
      // single requester, 20 RUN cycles
      req_valid = 2'b01;
      req_size0 = 5'd9;
      run_job(1'b0, 5'd9, 20, 1'b1);
      // continuous contention alternates 0,1,0,1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_size0 = 5'd5;
      req_size1 = 5'd7;
      req_valid = 2'b11;
      run_job(1'b0, 5'd5, 3, 1'b0);
      run_job(1'b1, 5'd7, 3, 1'b0);
      run_job(1'b0, 5'd5, 3, 1'b0);
      run_job(1'b1, 5'd7, 3, 1'b0);
      req_valid = 2'b00;
      // size-0 job finishes without starting the core
      req_size1 = 5'd0;
      req_valid = 2'b10;
      tick();
      check("zero_ready", 32'(ready_a), 32'h2);
      check("zero_start_g", 32'(start_a), 32'h0);
      req_valid = 2'b00;
      tick();
      check("zero_done", 32'(done_a), 32'h2);
      check("zero_start_f", 32'(start_a), 32'h0);
      tick();
      check("zero_idle", 32'(busy_a), 32'h0);
      // timeout with TIMEOUT_CYCLES=8
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_size0 = 5'd4;
      req_valid = 2'b01;
      tick();
      check("to_ready", 32'(ready_b), 32'h1);
      req_valid = 2'b00;
      tick();
      check("to_start", 32'(start_b), 32'h1);
      tick();
      for (int i = 1; i < 8; i++) begin
         if (err_b !== 2'b00 || done_b !== 2'b00) check("to_early", {err_b, done_b}, 32'h0);
         tick();
      end
      check("to_run8_busy", 32'(busy_b), 32'h1);
      tick();
      check("to_err", 32'(err_b), 32'h1);
      check("to_nodone", 32'(done_b), 32'h0);
      tick();
      check("to_idle", 32'(busy_b), 32'h0);
      req_valid = 2'b11;
      tick();
      check("to_next_grant", 32'(ready_b), 32'h2);
      req_valid = 2'b00;
      tick();
      check("to_zero_done", 32'(done_b), 32'h2);
      tick();
      // done on the threshold cycle wins
      req_valid = 2'b01;
      tick();
      check("tie_ready", 32'(ready_b), 32'h1);
      req_valid = 2'b00;
      tick();
      tick();
      for (int i = 1; i < 8; i++) tick();
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      check("tie_done", 32'(done_b), 32'h1);
      check("tie_noerr", 32'(err_b), 32'h0);
      tick();
      check("tie_idle", {busy_b, err_b}, 32'h0);
      // reset mid-run
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req_size1 = 5'd6;
      req_valid = 2'b10;
      tick();
      check("mid_ready", 32'(ready_a), 32'h2);
      req_valid = 2'b00;
      tick();
      tick();
      tick();
      check("mid_running", 32'(busy_a), 32'h1);
      rst = 1'b1;
      tick();
      check("mid_rst_out", {ready_a, done_a, err_a, start_a, busy_a, sel_a, size_a}, 32'h0);
      rst = 1'b0;
      tick();
      check("mid_after", {done_a, err_a, busy_a}, 32'h0);
      req_valid = 2'b11;
      tick();
      check("mid_regrant", 32'(ready_a), 32'h1);
      req_valid = 2'b00;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
